// File: rtl/mul_div_if.sv
// Request/response bundle between the EX stage and the multi-cycle multiply/divide unit.
interface mul_div_if #(
    parameter int WIDTH = 32
);
    logic             START;
    logic [4:0]       ALUOP;
    logic [WIDTH-1:0] OPERAND1;
    logic [WIDTH-1:0] OPERAND2;
    logic             FLUSH;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] RESULT;

    modport master (output START, ALUOP, OPERAND1, OPERAND2, FLUSH,
                    input  BUSY, DONE, RESULT);
    modport slave  (input  START, ALUOP, OPERAND1, OPERAND2, FLUSH,
                    output BUSY, DONE, RESULT);
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle RV32M multiply/divide unit: shift-add multiply, restoring divide,
// both on operand magnitudes with a one-cycle sign fix-up before the result is registered.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic     CLK,
    input  logic     RESET,
    mul_div_if.slave bus
);
    localparam logic [4:0] OP_MUL    = 5'b01011;
    localparam logic [4:0] OP_MULH   = 5'b01100;
    localparam logic [4:0] OP_MULHSU = 5'b01101;
    localparam logic [4:0] OP_MULHU  = 5'b01110;
    localparam logic [4:0] OP_DIV    = 5'b01111;
    localparam logic [4:0] OP_DIVU   = 5'b10000;
    localparam logic [4:0] OP_REM    = 5'b10001;
    localparam logic [4:0] OP_REMU   = 5'b10010;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t             r_state;
    logic [4:0]         r_op;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_ma;
    logic [WIDTH-1:0]   r_mb;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH:0]     r_rem;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH-1:0]   r_result;

    function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
        return -v;
    endfunction

    logic             w_valid_op, w_sgn1_en, w_sgn2_en, w_sign1, w_sign2;
    logic             w_is_div, w_is_rem, w_div0, w_ovf;
    logic [WIDTH-1:0] w_mag1, w_mag2, w_fast;

    assign w_valid_op = bus.ALUOP inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                                          OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    assign w_sgn1_en  = bus.ALUOP inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    assign w_sgn2_en  = bus.ALUOP inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    assign w_sign1    = w_sgn1_en & bus.OPERAND1[WIDTH-1];
    assign w_sign2    = w_sgn2_en & bus.OPERAND2[WIDTH-1];
    assign w_mag1     = w_sign1 ? f_neg(bus.OPERAND1) : bus.OPERAND1;
    assign w_mag2     = w_sign2 ? f_neg(bus.OPERAND2) : bus.OPERAND2;
    assign w_is_div   = bus.ALUOP inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    assign w_is_rem   = bus.ALUOP inside {OP_REM, OP_REMU};
    assign w_div0     = w_is_div && (bus.OPERAND2 == '0);
    assign w_ovf      = (bus.ALUOP inside {OP_DIV, OP_REM}) &&
                        (bus.OPERAND1 == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.OPERAND2 == '1);
    // Divide-by-zero and signed overflow results are fixed by the ISA, no iteration needed.
    assign w_fast     = w_div0 ? (w_is_rem ? bus.OPERAND1 : '1)
                               : (w_is_rem ? '0 : bus.OPERAND1);

    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH+1:0] w_shift, w_diff;

    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_ma} : '0);
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_diff    = w_shift - {2'b00, r_mb};

    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo, w_remv, w_fix;

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quo  = r_neg_q ? f_neg(r_quo) : r_quo;
    assign w_remv = r_neg_r ? f_neg(r_rem[WIDTH-1:0]) : r_rem[WIDTH-1:0];

    always_comb begin
        w_fix = w_remv;
        case (r_op)
            OP_MUL:                       w_fix = w_prod[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_fix = w_prod[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              w_fix = w_quo;
            default:                      w_fix = w_remv;
        endcase
    end

    assign bus.BUSY   = (r_state != S_IDLE);
    assign bus.DONE   = (r_state == S_DONE);
    assign bus.RESULT = r_result;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_cnt    <= '0;
            r_ma     <= '0;
            r_mb     <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_acc    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.START && !bus.FLUSH && w_valid_op) begin
                        r_op    <= bus.ALUOP;
                        r_ma    <= w_mag1;
                        r_mb    <= w_mag2;
                        r_acc   <= {{WIDTH{1'b0}}, w_mag2};
                        r_quo   <= w_mag1;
                        r_rem   <= '0;
                        r_neg_q <= w_sign1 ^ w_sign2;
                        r_neg_r <= w_sign1;
                        r_cnt   <= CNT_W'(WIDTH - 1);
                        if (w_div0 || w_ovf) begin
                            r_result <= w_fast;
                            r_state  <= S_DONE;
                        end else begin
                            r_state  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (bus.FLUSH) begin
                        r_state <= S_IDLE;
                    end else begin
                        // Both datapaths step every cycle; FIX picks the one the op needs.
                        r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
                        r_rem <= w_diff[WIDTH+1] ? w_shift[WIDTH:0] : w_diff[WIDTH:0];
                        r_quo <= {r_quo[WIDTH-2:0], ~w_diff[WIDTH+1]};
                        if (r_cnt == '0) r_state <= S_FIX;
                        else             r_cnt   <= r_cnt - CNT_W'(1);
                    end
                end
                S_FIX: begin
                    if (bus.FLUSH) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_result <= w_fix;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit with a cycle-level reference model of BUSY/DONE/RESULT.
module tb_mul_div_unit;
    localparam int WIDTH = 32;
    localparam logic [4:0] OP_MUL    = 5'b01011;
    localparam logic [4:0] OP_MULH   = 5'b01100;
    localparam logic [4:0] OP_MULHSU = 5'b01101;
    localparam logic [4:0] OP_MULHU  = 5'b01110;
    localparam logic [4:0] OP_DIV    = 5'b01111;
    localparam logic [4:0] OP_DIVU   = 5'b10000;
    localparam logic [4:0] OP_REM    = 5'b10001;
    localparam logic [4:0] OP_REMU   = 5'b10010;

    logic CLK = 1'b0;
    logic RESET;
    int   n_checks = 0;
    int   n_fail   = 0;

    mul_div_if #(.WIDTH(WIDTH)) mif ();

    mul_div_unit #(.WIDTH(WIDTH), .CNT_W(5)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (mif)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of an M-extension op, from 64-bit integer arithmetic.
    function automatic logic [31:0] ref_fn(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = '0;
        case (op)
            OP_MUL:    p = sa * sb;
            OP_MULH:   p = (sa * sb) >> 32;
            OP_MULHSU: p = (sa * longint'(ub)) >> 32;
            OP_MULHU:  p = (ua * ub) >> 32;
            OP_DIV: begin
                if (b == 0) p = 64'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = 64'h8000_0000;
                else p = sa / sb;
            end
            OP_DIVU:   p = (b == 0) ? 64'hFFFF_FFFF : ua / ub;
            OP_REM: begin
                if (b == 0) p = ua;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = 0;
                else p = sa % sb;
            end
            OP_REMU:   p = (b == 0) ? ua : ua % ub;
            default:   p = '0;
        endcase
        return p[31:0];
    endfunction

    function automatic bit is_valid(input logic [4:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

    function automatic bit is_fast(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if ((op == OP_DIV || op == OP_DIVU || op == OP_REM || op == OP_REMU) && b == 0) return 1'b1;
        if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
        return 1'b0;
    endfunction

    // Model: an accepted op occupies the unit for m_lat cycles, DONE in the last one.
    bit          m_act  = 1'b0;
    int          m_cnt  = 0;
    int          m_lat  = 0;
    logic [31:0] m_res  = '0;
    logic [31:0] m_pend = '0;

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            m_act = 1'b0; m_cnt = 0; m_lat = 0; m_res = '0; m_pend = '0;
        end else if (m_act) begin
            if (m_cnt == m_lat || mif.FLUSH) begin
                m_act = 1'b0;
            end else begin
                m_cnt++;
                if (m_cnt == m_lat) m_res = m_pend;
            end
        end else if (mif.START && !mif.FLUSH && is_valid(mif.ALUOP)) begin
            m_act  = 1'b1;
            m_cnt  = 1;
            m_lat  = is_fast(mif.ALUOP, mif.OPERAND1, mif.OPERAND2) ? 1 : WIDTH + 2;
            m_pend = ref_fn(mif.ALUOP, mif.OPERAND1, mif.OPERAND2);
            if (m_lat == 1) m_res = m_pend;
        end
    end

    always @(negedge CLK) begin
        check("cyc busy",   {31'd0, mif.BUSY}, {31'd0, m_act});
        check("cyc done",   {31'd0, mif.DONE}, {31'd0, (m_act && m_cnt == m_lat)});
        check("cyc result", mif.RESULT, m_res);
    end

    task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int lat;
        bit got;
        check({name, " model"}, ref_fn(op, a, b), exp);
        @(posedge CLK); #1;
        mif.START = 1'b1; mif.ALUOP = op; mif.OPERAND1 = a; mif.OPERAND2 = b;
        @(posedge CLK); #1;
        mif.START = 1'b0;
        lat = 0;
        got = 1'b0;
        for (int i = 1; i <= 100 && !got; i++) begin
            @(negedge CLK);
            if (mif.DONE) begin got = 1'b1; lat = i; end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: no DONE within 100 cycles", name);
        end else begin
            check({name, " latency"}, lat, exp_lat);
            check({name, " result"}, mif.RESULT, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_seen;
        RESET = 1'b0;
        mif.START = 1'b0; mif.FLUSH = 1'b0; mif.ALUOP = '0;
        mif.OPERAND1 = '0; mif.OPERAND2 = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset busy",   {31'd0, mif.BUSY}, 32'd0);
        check("reset done",   {31'd0, mif.DONE}, 32'd0);
        check("reset result", mif.RESULT, 32'd0);
        @(posedge CLK); #1;
        RESET = 1'b1;

        run_op("MUL 10*20",        OP_MUL,    32'd10,          32'd20,          32'd200,         34);
        run_op("MUL 1*-1",         OP_MUL,    32'd1,           32'hFFFF_FFFF,   32'hFFFF_FFFF,   34);
        run_op("MULH 4*-1",        OP_MULH,   32'd4,           32'hFFFF_FFFF,   32'hFFFF_FFFF,   34);
        run_op("MULHSU 4*ffffffff", OP_MULHSU, 32'd4,          32'hFFFF_FFFF,   32'd3,           34);
        run_op("MULHU 4*ffffffff", OP_MULHU,  32'd4,           32'hFFFF_FFFF,   32'd3,           34);
        run_op("MULHU max*max",    OP_MULHU,  32'hFFFF_FFFF,   32'hFFFF_FFFF,   32'hFFFF_FFFE,   34);
        run_op("MUL 0*x",          OP_MUL,    32'd0,           32'h1234_5678,   32'd0,           34);
        run_op("DIV 20/10",        OP_DIV,    32'd20,          32'd10,          32'd2,           34);
        run_op("DIVU 20/10",       OP_DIVU,   32'd20,          32'd10,          32'd2,           34);
        run_op("DIV -7/2",         OP_DIV,    32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFD,   34);
        run_op("REM -7/2",         OP_REM,    32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFF,   34);
        run_op("REMU 7/2",         OP_REMU,   32'd7,           32'd2,           32'd1,           34);
        run_op("DIV 7/-2",         OP_DIV,    32'd7,           32'hFFFF_FFFE,   32'hFFFF_FFFD,   34);
        run_op("REM 7/-2",         OP_REM,    32'd7,           32'hFFFF_FFFE,   32'd1,           34);
        run_op("DIVU max/3",       OP_DIVU,   32'hFFFF_FFFF,   32'd3,           32'h5555_5555,   34);
        run_op("DIV 5/0",          OP_DIV,    32'd5,           32'd0,           32'hFFFF_FFFF,   1);
        run_op("REMU 5/0",         OP_REMU,   32'd5,           32'd0,           32'd5,           1);
        run_op("DIV ovf",          OP_DIV,    32'h8000_0000,   32'hFFFF_FFFF,   32'h8000_0000,   1);
        run_op("REM ovf",          OP_REM,    32'h8000_0000,   32'hFFFF_FFFF,   32'd0,           1);
        run_op("MUL 6*7",          OP_MUL,    32'd6,           32'd7,           32'd42,          34);

        // Abort a multiply in its tenth busy cycle.
        @(posedge CLK); #1;
        mif.START = 1'b1; mif.ALUOP = OP_MUL; mif.OPERAND1 = 32'd7; mif.OPERAND2 = 32'd9;
        @(posedge CLK); #1;
        mif.START = 1'b0;
        repeat (9) @(posedge CLK);
        #1 mif.FLUSH = 1'b1;
        @(posedge CLK); #1;
        mif.FLUSH = 1'b0;
        check("flush busy",   {31'd0, mif.BUSY}, 32'd0);
        check("flush result", mif.RESULT, 32'd42);
        done_seen = 0;
        repeat (40) begin
            @(negedge CLK);
            if (mif.DONE) done_seen++;
        end
        check("flush no done", done_seen, 32'd0);

        @(posedge CLK); #1;
        mif.START = 1'b1; mif.FLUSH = 1'b1; mif.ALUOP = OP_MUL;
        @(posedge CLK); #1;
        mif.START = 1'b0; mif.FLUSH = 1'b0;
        check("flush+start idle", {31'd0, mif.BUSY}, 32'd0);

        run_op("MUL 3*3",          OP_MUL,    32'd3,           32'd3,           32'd9,           34);

        // Asynchronous reset in the fifth busy cycle.
        @(posedge CLK); #1;
        mif.START = 1'b1; mif.ALUOP = OP_MUL; mif.OPERAND1 = 32'd5; mif.OPERAND2 = 32'd5;
        @(posedge CLK); #1;
        mif.START = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        check("pre-reset busy", {31'd0, mif.BUSY}, 32'd1);
        RESET = 1'b0;
        #1;
        check("async rst busy",   {31'd0, mif.BUSY}, 32'd0);
        check("async rst done",   {31'd0, mif.DONE}, 32'd0);
        check("async rst result", mif.RESULT, 32'd0);
        @(posedge CLK); #1;
        RESET = 1'b1;

        @(posedge CLK); #1;
        mif.START = 1'b1; mif.ALUOP = 5'b00001;
        @(posedge CLK); #1;
        mif.START = 1'b0;
        check("ADD ignored busy", {31'd0, mif.BUSY}, 32'd0);
        repeat (3) @(posedge CLK);
        #1 check("ADD ignored later", {31'd0, mif.BUSY}, 32'd0);

        @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
